if_prefetch_stage: RTL and testbench
====================================

Name: if_prefetch_stage

Overview:
- Parametrised next-generation instruction fetch stage. It decouples PC generation from instruction memory latency using an in-order request/response port and a prefetch FIFO of depth FIFO_DEPTH.
- Supplies the IF/ID pipeline register (valid, PC+4, instruction) to ID.
- Applies redirect priority: interrupt > exception > branch/jump/jr.
- Flushes in-flight fetches on any redirect.

Parameters:
- ADDR_W, 32, PC/address width, ≥8; bit ADDR_W-1 is the kernel bit.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of 2, ≥2.
- RESET_VEC, 32'h8000_0000, PC after reset (truncated to ADDR_W).
- IRQ_VEC, 32'h8000_0004, interrupt vector.
- EXC_VEC, 32'h8000_0008, exception vector.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, accepted on the same cycle.
- imem_addr  out  ADDR_W  fetch address (current fetch PC).
- imem_valid  in  1  response strobe; responses are in order, latency ≥1 cycle, cannot be stalled.
- imem_rdata  in  32  response instruction.
- id_ready  in  1  ID can accept (PC/IF_ID write enable).
- select_PC_next  in  3  {Z, J, JR}, one-hot or zero.
- branch_target  in  ADDR_W  target when Z is set.
- jump_target  in  ADDR_W  target when J is set.
- jr_target  in  ADDR_W  target when JR is set.
- status  in  2  {interrupt, exception}.
- if_id_valid  out  1  IF_ID holds a real instruction.
- if_id_pc_plus4  out  ADDR_W  PC+4 of the IF_ID instruction.
- if_id_instr  out  32  instruction; 0 (NOP) when invalid.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - Fetch PC = RESET_VEC.
  - FIFO empty; outstanding and drop counters = 0.
  - if_id_valid=0, if_id_pc_plus4=0, if_id_instr=0, imem_req=0.
- Increment: pc_plus4 = {pc[ADDR_W-1], pc[ADDR_W-2:0]+4}. The kernel bit is preserved; the lower bits wrap within ADDR_W-1 bits.
- Request issue:
  - imem_req=1 when (fifo_count + outstanding) < FIFO_DEPTH and no redirect is active this cycle.
  - On issue, fetch PC <= pc_plus4 and outstanding increments.
  - This guarantees the FIFO can never overflow.
- Response handling:
  - On imem_valid, outstanding decrements.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {addr+4, imem_rdata} is pushed into the FIFO. Each FIFO entry stores its pc_plus4.
- Redirect is active when status != 0 or select_PC_next != 0. Next fetch PC:
  - status=10: IRQ_VEC.
  - status=01: EXC_VEC.
  - status=11: all-ones.
  - status=00, select 100: branch_target.
  - status=00, select 010: jump_target.
  - status=00, select 001: jr_target.
  - any other non-zero select: all-ones.
- Redirect effects:
  - Applied regardless of id_ready.
  - FIFO cleared.
  - drop_cnt <= outstanding minus any response consumed this cycle; a response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - IF_ID <= bubble: valid=0, instr=0, pc_plus4 unchanged.
- Output register (no redirect):
  - id_ready=1 and FIFO non-empty: pop head into IF_ID with valid=1.
  - id_ready=1 and FIFO empty: bubble (valid=0, instr=0).
  - id_ready=0: hold.
- Latency without bypass:
  - Response edge E: entry written to FIFO.
  - Edge E+1: earliest load into IF_ID.
- Simultaneous push and pop on the same edge is legal; the count is unchanged.
- Back-to-back redirects: each one re-computes drop_cnt from the live outstanding count.

Optional Feature:
- Macro: IF_PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, id_ready=1, no redirect, and a non-dropped response arrives, it is written directly into IF_ID at edge E (valid=1) and not pushed into the FIFO. This saves one cycle.
- Undefined: every response passes through the FIFO, giving the E+1 latency above.

Test Plan:
- Reset with rst=1 mid-run, then release -> imem_addr=8000_0000, if_id_valid=0, fifo_count=0; with 1-cycle memory and id_ready=1, IF_ID pc_plus4 sequence is 8000_0004, 8000_0008, 8000_000C.
- id_ready=0 for 10 cycles with 1-cycle memory -> imem_req stops once fifo_count=4; IF_ID holds; on release, 4 instructions pop in order with no loss or duplicate.
- 3-cycle memory with 3 requests in flight, then branch redirect (select=100, target=8000_0100) -> next response pushes drop 3; first valid IF_ID has pc_plus4=8000_0104; the cycle after the redirect shows a bubble.
- status=10 and select=100 in the same cycle -> PC=8000_0004 (interrupt wins); status=01 -> 8000_0008; status=11 -> FFFF_FFFF.
- Fetch at PC=7FFF_FFFC -> pc_plus4=0000_0000 (kernel bit 0 kept); at FFFF_FFFC -> 8000_0000.
- With IF_PREFETCH_BYPASS_EN, empty FIFO, 1-cycle memory -> instruction appears in IF_ID at the response edge and fifo_count stays 0; without the macro, it appears one edge later.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: instruction fetch stage with a prefetch FIFO.
// Issues in-order fetch requests ahead of decode, buffers the responses in a
// FIFO_DEPTH-entry FIFO, and feeds the IF/ID register. Redirects (interrupt >
// exception > branch/jump/jr) flush the FIFO and discard in-flight responses.
// Optional feature: define IF_PREFETCH_BYPASS_EN to let a response go straight
// into IF/ID when the FIFO is empty and decode is ready (one cycle earlier).
module if_prefetch_stage #(
  parameter int          ADDR_W     = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC    = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC    = 32'h8000_0008
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic                          imem_valid,
  input  logic [31:0]                   imem_rdata,
  input  logic                          id_ready,
  input  logic [2:0]                    select_PC_next,
  input  logic [ADDR_W-1:0]             branch_target,
  input  logic [ADDR_W-1:0]             jump_target,
  input  logic [ADDR_W-1:0]             jr_target,
  input  logic [1:0]                    status,
  output logic                          if_id_valid,
  output logic [ADDR_W-1:0]             if_id_pc_plus4,
  output logic [31:0]                   if_id_instr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Sequential increment that keeps the kernel bit and wraps the low bits.
  function automatic logic [ADDR_W-1:0] inc_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1], a[ADDR_W-2:0] + (ADDR_W-1)'(4)};
  endfunction

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] fifo_pc4   [FIFO_DEPTH];
  logic [31:0]       fifo_instr [FIFO_DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              resp_drop;
  logic              resp_keep;
  logic              pop;
  logic              push;
  logic              bypass;
  logic [ADDR_W-1:0] resp_pc4;

  assign redirect  = (status != '0) || (select_PC_next != '0);
  assign occupancy = {1'b0, count} + {1'b0, outstanding};
  assign issue     = !rst && !redirect && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign resp_drop = imem_valid && (drop_cnt != '0);
  // Responses landing in a redirect cycle belong to the old stream.
  assign resp_keep = imem_valid && (drop_cnt == '0) && !redirect;
  assign pop       = !redirect && id_ready && (count != '0);
  assign resp_pc4  = inc_pc(resp_pc);

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = resp_keep && id_ready && (count == '0);
`else
  assign bypass = 1'b0;
`endif
  assign push = resp_keep && !bypass;

  assign imem_req   = issue;
  assign imem_addr  = pc;
  assign fifo_count = count;

  // Redirect target selection: interrupt, then exception, then control flow.
  always_comb begin
    redirect_pc = '1;
    case (status)
      2'b10:   redirect_pc = ADDR_W'(IRQ_VEC);
      2'b01:   redirect_pc = ADDR_W'(EXC_VEC);
      2'b11:   redirect_pc = '1;
      default: begin
        case (select_PC_next)
          3'b100:  redirect_pc = branch_target;
          3'b010:  redirect_pc = jump_target;
          3'b001:  redirect_pc = jr_target;
          default: redirect_pc = '1;
        endcase
      end
    endcase
  end

  // Fetch PC and the address of the next expected (non-dropped) response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= ADDR_W'(RESET_VEC);
      resp_pc <= ADDR_W'(RESET_VEC);
    end else if (redirect) begin
      pc      <= redirect_pc;
      resp_pc <= redirect_pc;
    end else begin
      if (issue)     pc      <= inc_pc(pc);
      if (resp_keep) resp_pc <= resp_pc4;
    end
  end

  // In-flight request tracking and stale-response drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_valid);
      if (redirect)       drop_cnt <= outstanding - CNT_W'(imem_valid);
      else if (resp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  // FIFO occupancy and pointers; a redirect empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count + CNT_W'(push) - CNT_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
    end
  end

  // FIFO storage: each entry holds the instruction and its PC+4.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc4[wr_ptr]   <= resp_pc4;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  // IF/ID register: bubble on redirect, load or bubble when ID is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_pc_plus4 <= '0;
      if_id_instr    <= '0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
    end else if (id_ready) begin
      if (pop) begin
        if_id_valid    <= 1'b1;
        if_id_pc_plus4 <= fifo_pc4[rd_ptr];
        if_id_instr    <= fifo_instr[rd_ptr];
      end else if (bypass) begin
        if_id_valid    <= 1'b1;
        if_id_pc_plus4 <= resp_pc4;
        if_id_instr    <= imem_rdata;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Testbench for if_prefetch_stage: randomized fetch/redirect traffic against
// an in-order memory model, with a scoreboard of expected IF/ID contents.
module tb_if_prefetch_stage;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_V = 32'h8000_0000;
  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          id_ready = 1'b0;
  logic [2:0]    select_PC_next = '0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] jump_target = '0;
  logic [AW-1:0] jr_target = '0;
  logic [1:0]    status = '0;
  logic          if_id_valid;
  logic [AW-1:0] if_id_pc_plus4;
  logic [31:0]   if_id_instr;
  logic [2:0]    fifo_count;

  if_prefetch_stage #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .select_PC_next(select_PC_next), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .status(status),
    .if_id_valid(if_id_valid), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] pc4; logic [31:0] instr; } exp_t;
  typedef struct { logic [AW-1:0] addr; int due; } req_t;

  exp_t expq[$];
  req_t pend[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_due = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit e_ready = 1'b0;
  bit e_redir = 1'b0;
  logic [AW-1:0] model_pc = RST_V;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [AW-1:0] plus4(input logic [AW-1:0] a);
    logic [AW-1:0] msb;
    msb = {1'b1, {(AW-1){1'b0}}};
    return ((a + 32'd4) & ~msb) | (a & msb);
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [AW-1:0] redir_target(input logic [1:0] st, input logic [2:0] sel,
      input logic [AW-1:0] bt, input logic [AW-1:0] jt, input logic [AW-1:0] jrt);
    if (st == 2'b10) return IRQ_V;
    if (st == 2'b01) return EXC_V;
    if (st == 2'b11) return {AW{1'b1}};
    if (sel == 3'b100) return bt;
    if (sel == 3'b010) return jt;
    if (sel == 3'b001) return jrt;
    return {AW{1'b1}};
  endfunction

  // One clock edge: check the request rule, advance the model and memory.
  task automatic tick();
    logic s_req;
    logic [AW-1:0] s_addr;
    logic [AW-1:0] tgt;
    bit s_redir;
    int pcnt;
    int due;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_redir = (status != 2'b00) || (select_PC_next != 3'b000);
    pcnt    = pend.size() + (imem_valid ? 1 : 0);
    chk("req_rule", 64'(s_req), 64'(!s_redir && ((int'(fifo_count) + pcnt) < DEPTH)));
    if (s_req) chk("fetch_addr", 64'(s_addr), 64'(model_pc));
    tgt = redir_target(status, select_PC_next, branch_target, jump_target, jr_target);
    @(posedge clk);
    #1;
    cyc++;
    e_ready = id_ready;
    e_redir = s_redir;
    if (s_redir) begin
      expq.delete();
      model_pc = tgt;
    end else if (s_req) begin
      expq.push_back('{plus4(model_pc), mem_word(model_pc)});
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{s_addr, due});
      model_pc = plus4(model_pc);
    end
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      imem_valid = 1'b1;
      imem_rdata = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_valid = 1'b0;
    #1;
    chk("rst_addr", 64'(imem_addr), 64'(RST_V));
    chk("rst_req", 64'(imem_req), 64'(0));
    chk("rst_valid", 64'(if_id_valid), 64'(0));
    chk("rst_pc4", 64'(if_id_pc_plus4), 64'(0));
    chk("rst_instr", 64'(if_id_instr), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    pend.delete();
    expq.delete();
    model_pc = RST_V;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_addr", 64'(imem_addr), 64'(RST_V));
    chk("post_rst_req", 64'(imem_req), 64'(1));
  endtask

  task automatic redirect_once(input logic [1:0] st, input logic [2:0] sel, input logic [AW-1:0] t);
    status = st;
    select_PC_next = sel;
    branch_target = t;
    jump_target = t;
    jr_target = t;
    tick();
    status = 2'b00;
    select_PC_next = 3'b000;
  endtask

  // Monitor: compares every newly loaded IF/ID value against the scoreboard.
  initial begin : monitor
    int mc;
    logic pv;
    logic [AW-1:0] ppc;
    logic [31:0] pin;
    exp_t e;
    mc = 0; pv = 1'b0; ppc = '0; pin = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pv = 1'b0; ppc = '0; pin = '0; mc = cyc;
      end else if (cyc != mc) begin
        mc = cyc;
        if (e_redir) begin
          chk("redir_valid", 64'(if_id_valid), 64'(0));
          chk("redir_instr", 64'(if_id_instr), 64'(0));
          chk("redir_pc4_kept", 64'(if_id_pc_plus4), 64'(ppc));
        end else if (e_ready) begin
          if (if_id_valid) begin
            if (expq.size() == 0) begin
              chk("unexpected_instr", 64'(expq.size()), 64'(1));
            end else begin
              e = expq.pop_front();
              chk("ifid_pc4", 64'(if_id_pc_plus4), 64'(e.pc4));
              chk("ifid_instr", 64'(if_id_instr), 64'(e.instr));
            end
          end else begin
            chk("bubble_instr", 64'(if_id_instr), 64'(0));
          end
        end else begin
          chk("hold_valid", 64'(if_id_valid), 64'(pv));
          chk("hold_pc4", 64'(if_id_pc_plus4), 64'(ppc));
          chk("hold_instr", 64'(if_id_instr), 64'(pin));
        end
        chk("fifo_bound", 64'(int'(fifo_count) <= DEPTH), 64'(1));
        pv = if_id_valid; ppc = if_id_pc_plus4; pin = if_id_instr;
      end
    end
  end

  initial begin : stimulus
    logic [2:0] sels [7] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111};
    logic [AW-1:0] t;
    do_reset();
    id_ready = 1'b1;
    repeat (8) tick();

    // Reset in the middle of traffic, then restart from the reset vector.
    do_reset();
    repeat (6) tick();

    // Decode stall: prefetch fills the FIFO and stops requesting.
    id_ready = 1'b0;
    repeat (10) tick();
    #1;
    chk("stall_count", 64'(fifo_count), 64'(DEPTH));
    chk("stall_req", 64'(imem_req), 64'(0));
    id_ready = 1'b1;
    repeat (8) tick();

    // Three-cycle memory with requests in flight, then a branch.
    lat_min = 3; lat_max = 3;
    repeat (8) tick();
    redirect_once(2'b00, 3'b100, 32'h8000_0100);
    chk("branch_pc", 64'(imem_addr), 64'(32'h8000_0100));
    repeat (10) tick();

    // Redirect priority.
    lat_min = 1; lat_max = 1;
    repeat (4) tick();
    redirect_once(2'b10, 3'b100, 32'h1234_5670);
    chk("irq_pc", 64'(imem_addr), 64'(IRQ_V));
    repeat (3) tick();
    redirect_once(2'b01, 3'b010, 32'h1234_5670);
    chk("exc_pc", 64'(imem_addr), 64'(EXC_V));
    repeat (3) tick();
    redirect_once(2'b11, 3'b000, 32'h1234_5670);
    chk("both_pc", 64'(imem_addr), 64'(32'hFFFF_FFFF));
    repeat (4) tick();

    // Kernel bit preserved across the increment.
    redirect_once(2'b00, 3'b010, 32'h7FFF_FFFC);
    tick();
    chk("kwrap_user", 64'(imem_addr), 64'(32'h0000_0000));
    repeat (4) tick();
    redirect_once(2'b00, 3'b001, 32'hFFFF_FFFC);
    tick();
    chk("kwrap_kernel", 64'(imem_addr), 64'(32'h8000_0000));
    repeat (4) tick();

    // Response-to-IF/ID latency with an empty FIFO.
    redirect_once(2'b00, 3'b010, 32'h8000_0200);
    tick();
    tick();
    #1;
`ifdef IF_PREFETCH_BYPASS_EN
    chk("bypass_valid", 64'(if_id_valid), 64'(1));
    chk("bypass_pc4", 64'(if_id_pc_plus4), 64'(32'h8000_0204));
    chk("bypass_count", 64'(fifo_count), 64'(0));
`else
    chk("nobypass_valid", 64'(if_id_valid), 64'(0));
    chk("nobypass_count", 64'(fifo_count), 64'(1));
`endif
    tick();
    #1;
    chk("late_valid", 64'(if_id_valid), 64'(1));
`ifdef IF_PREFETCH_BYPASS_EN
    chk("late_pc4", 64'(if_id_pc_plus4), 64'(32'h8000_0208));
`else
    chk("late_pc4", 64'(if_id_pc_plus4), 64'(32'h8000_0204));
`endif

    // Randomized traffic with variable memory latency and redirects.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      id_ready = ($urandom_range(3, 0) != 0);
      status = 2'b00;
      select_PC_next = 3'b000;
      if ($urandom_range(11, 0) == 0) begin
        status = 2'($urandom_range(3, 0));
        if ($urandom_range(1, 0) == 0) status = 2'b00;
        select_PC_next = sels[$urandom_range(6, 0)];
        t = {$urandom} & 32'hFFFF_FFFC;
        if ($urandom_range(7, 0) == 0) t = 32'h7FFF_FFF8;
        branch_target = t;
        jump_target = {$urandom} & 32'hFFFF_FFFC;
        jr_target = {$urandom} & 32'hFFFF_FFFC;
      end
      tick();
    end

    // Drain: with decode always ready the backlog stays within the FIFO size.
    id_ready = 1'b1;
    status = 2'b00;
    select_PC_next = 3'b000;
    repeat (20) tick();
    chk("backlog", 64'(expq.size() <= DEPTH), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
